// File: rtl/fifo_wptr_full_if.sv
// Write-side FIFO pointer bundle: producer handshake, the incoming read pointer,
// and the write-domain status published back to the producer.
interface fifo_wptr_full_if #(
  parameter int ptrsize = 10
);
  logic               wr_en;
  logic [ptrsize:0]   rptr_gray;
  logic [ptrsize-1:0] waddr;
  logic [ptrsize:0]   wptr_gray;
  logic               wfull;
  logic               walmost_full;
  logic [ptrsize:0]   wlevel;
  logic               wr_err;

  modport master (
    output wr_en, rptr_gray,
    input  waddr, wptr_gray, wfull, walmost_full, wlevel, wr_err
  );

  modport slave (
    input  wr_en, rptr_gray,
    output waddr, wptr_gray, wfull, walmost_full, wlevel, wr_err
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write pointer and full/almost-full/level generator for an asynchronous FIFO.
// Gray write pointer is published straight from a flop; read pointer is double-synchronized.
module fifo_wptr_full #(
  parameter int ptrsize   = 10,
  parameter int af_margin = 2
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wptr_full_if.slave  bus
);
  localparam logic [ptrsize:0] depth_v = {1'b1, {ptrsize{1'b0}}};
  localparam logic [ptrsize:0] af_v    = (ptrsize+1)'(af_margin);

  logic [ptrsize:0] wbin_reg;
  logic [ptrsize:0] wgray_reg;
  logic [ptrsize:0] rq1_reg;
  logic [ptrsize:0] rq2_reg;
  logic             wfull_reg;
  logic             walmost_full_reg;
  logic [ptrsize:0] wlevel_reg;
  logic             wr_err_reg;

  logic             push;
  logic [ptrsize:0] wbin_next;
  logic [ptrsize:0] wgray_next;
  logic [ptrsize:0] rbin_sync;
  logic [ptrsize:0] level_next;
  logic [ptrsize:0] free_next;
  logic [ptrsize:0] full_cmp;
  logic             wfull_next;
  logic             walmost_full_next;

  // Writes while full are dropped; the pointer only moves on an accepted push.
  assign push       = bus.wr_en & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{ptrsize{1'b0}}, push};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ptrsize; gi++) begin : g_rbin
      assign rbin_sync[gi] = ^rq2_reg[ptrsize:gi];
    end
  endgenerate

  // Full when the writer sits exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp          = {~rq2_reg[ptrsize:ptrsize-1], rq2_reg[ptrsize-2:0]};
  assign wfull_next        = (wgray_next == full_cmp);
  assign level_next        = wbin_next - rbin_sync;
  assign free_next         = depth_v - level_next;
  assign walmost_full_next = (free_next <= af_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_reg         <= '0;
      wgray_reg        <= '0;
      rq1_reg          <= '0;
      rq2_reg          <= '0;
      wfull_reg        <= 1'b0;
      walmost_full_reg <= 1'b0;
      wlevel_reg       <= '0;
      wr_err_reg       <= 1'b0;
    end else begin
      wbin_reg         <= wbin_next;
      wgray_reg        <= wgray_next;
      rq1_reg          <= bus.rptr_gray;
      rq2_reg          <= rq1_reg;
      wfull_reg        <= wfull_next;
      walmost_full_reg <= walmost_full_next;
      wlevel_reg       <= level_next;
      wr_err_reg       <= bus.wr_en & wfull_reg;
    end
  end

  assign bus.waddr        = wbin_reg[ptrsize-1:0];
  assign bus.wptr_gray    = wgray_reg;
  assign bus.wfull        = wfull_reg;
  assign bus.walmost_full = walmost_full_reg;
  assign bus.wlevel       = wlevel_reg;
  assign bus.wr_err       = wr_err_reg;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized and directed bench for fifo_wptr_full against a counting model
// of writes, reader position and a two-sample-old view of the reader.
module tb_fifo_wptr_full;
  localparam int P     = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 2;
  localparam int MOD   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wptr_full_if #(.ptrsize(P)) bus ();
  fifo_wptr_full #(.ptrsize(P), .af_margin(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  // Model: writes accepted (mod and total), reader samples seen at each edge.
  int m_wcnt, m_wtot, m_level;
  bit m_full, m_afull, m_err;
  int hist[$];
  int wcnt_hist[$];
  logic [P:0] prev_gray;

  function automatic logic [P:0] g(input int b);
    logic [P:0] v;
    v = b[P:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("waddr", int'(bus.waddr), m_wcnt % DEPTH);
    chk("wptr_gray", int'(bus.wptr_gray), int'(g(m_wcnt)));
    chk("wfull", int'(bus.wfull), int'(m_full));
    chk("walmost_full", int'(bus.walmost_full), int'(m_afull));
    chk("wlevel", int'(bus.wlevel), m_level);
    chk("wr_err", int'(bus.wr_err), int'(m_err));
    chk("gray_hamming_le1", int'($countones(bus.wptr_gray ^ prev_gray) <= 1), 1);
    prev_gray = bus.wptr_gray;
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_wtot = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_err = 0;
    hist.delete();
    wcnt_hist.delete();
    prev_gray = '0;
  endtask

  // Apply one cycle of stimulus; r is the reader's binary position.
  task automatic step(input bit w, input int r);
    int rsync;
    bus.wr_en     = w;
    bus.rptr_gray = g(r % MOD);
    m_err = w && m_full;
    if (w && !m_full) begin
      m_wcnt = (m_wcnt + 1) % MOD;
      m_wtot++;
    end
    hist.push_back(r % MOD);
    rsync   = (hist.size() >= 3) ? hist[hist.size()-3] : 0;
    m_level = (m_wcnt - rsync + MOD) % MOD;
    m_full  = (m_level == DEPTH);
    m_afull = ((DEPTH - m_level) <= AF);
    wcnt_hist.push_back(m_wcnt);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[8];
    int rcnt;
    seq = '{1, 3, 2, 6, 7, 5, 4, 12};
    bus.wr_en = 1'b0;
    bus.rptr_gray = '0;
    model_reset();

    // Reset state
    do_reset();
    chk("rst_wptr_gray", int'(bus.wptr_gray), 0);
    chk("rst_wlevel", int'(bus.wlevel), 0);
    chk("rst_wfull", int'(bus.wfull), 0);

    // Fill to full with reader parked at 0
    for (int i = 0; i < 8; i++) begin
      chk("fill_waddr", int'(bus.waddr), i);
      step(1, 0);
      chk("fill_gray_seq", int'(bus.wptr_gray), seq[i]);
    end
    chk("fill_wfull", int'(bus.wfull), 1);
    chk("fill_wlevel", int'(bus.wlevel), 8);

    // Overflow attempts
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk("ovf_wr_err", int'(bus.wr_err), 1);
      chk("ovf_gray_frozen", int'(bus.wptr_gray), 12);
    end

    // Reader advances to 1: visible on the third edge
    step(0, 1);
    chk("rd_lat_e1", int'(bus.wfull), 1);
    step(0, 1);
    chk("rd_lat_e2", int'(bus.wfull), 1);
    step(0, 1);
    chk("rd_lat_e3_full", int'(bus.wfull), 0);
    chk("rd_lat_e3_level", int'(bus.wlevel), 7);
    chk("refill_waddr", int'(bus.waddr), 0);
    step(1, 1);
    chk("refill_gray", int'(bus.wptr_gray), 13);
    chk("refill_full", int'(bus.wfull), 1);

    // Almost-full threshold
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("af_after5", int'(bus.walmost_full), 0);
    step(1, 0);
    chk("af_after6", int'(bus.walmost_full), 1);
    chk("af_level6", int'(bus.wlevel), 6);
    for (int i = 0; i < 3; i++) step(0, 2);
    chk("af_cleared", int'(bus.walmost_full), 0);

    // Wrap with reader trailing the writer by 4 cycles
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rcnt = (wcnt_hist.size() >= 4) ? wcnt_hist[wcnt_hist.size()-4] : 0;
      step(1, rcnt);
    end
    chk("wrap_total", m_wtot, 40);
    chk("wrap_no_full", int'(bus.wfull), 0);

    // Random traffic, reader never passes the writer
    do_reset();
    rcnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (rcnt < m_wtot && $urandom_range(0, 2) != 0) rcnt++;
      step(bit'($urandom_range(0, 1)), rcnt);
    end

    // Asynchronous reset during continuous writes
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("pre_rst_level", int'(bus.wlevel), 5);
    bus.wr_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_waddr", int'(bus.waddr), 0);
    chk("async_gray", int'(bus.wptr_gray), 0);
    chk("async_level", int'(bus.wlevel), 0);
    chk("async_full", int'(bus.wfull | bus.walmost_full | bus.wr_err), 0);
    do_reset();
    chk("post_rst_waddr", int'(bus.waddr), 0);
    step(1, 0);
    chk("post_rst_gray", int'(bus.wptr_gray), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag generator for the asynchronous FIFO; the encode-side counterpart to the read domain's Gray-to-binary decode.
- Keeps a binary write pointer and publishes a registered Gray-coded copy for crossing into the read domain.
- Synchronizes the read domain's Gray pointer into the write clock with two flops, decodes it, and produces full, almost-full, level and overflow-error indications for the writer.

Parameters:
ptrsize, 10, address width; FIFO depth = 2**ptrsize; pointers are ptrsize+1 bits (extra wrap bit); legal range ptrsize >= 2
af_margin, 2, almost_full asserts when free entries <= af_margin; legal range 0 .. 2**ptrsize-1

Ports:
clk  input  1  write-domain clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request from producer
rptr_gray  input  ptrsize+1  read pointer, Gray code, from read clock domain (asynchronous to clk)
waddr  output  ptrsize  RAM write address = wbin[ptrsize-1:0]
wptr_gray  output  ptrsize+1  registered Gray write pointer, to read-domain synchronizer
wfull  output  1  FIFO full, registered
walmost_full  output  1  free entries <= af_margin, registered
wlevel  output  ptrsize+1  occupied entries as seen by write side, 0 .. 2**ptrsize, registered
wr_err  output  1  one-cycle pulse: wr_en sampled while wfull=1

Behaviour:
- Reset (async assert, sync release): wbin, wptr_gray, both synchronizer stages, wfull, walmost_full, wlevel, wr_err all 0; waddr = 0.
- push = wr_en & ~wfull; a write while full is dropped: no pointer change, wr_err=1 on the next edge only.
- wbin_next = wbin + push, modulo 2**(ptrsize+1); wraps from all-ones to 0 with no special case.
- wgray_next = wbin_next ^ (wbin_next >> 1); wptr_gray <= wgray_next. It is driven directly from a flop, with no combinational logic after the register, and changes by at most one bit per clock.
- Synchronizer: rq1 <= rptr_gray; rq2 <= rq1. Only rq2 is used by downstream logic. rptr_gray is never used combinationally.
- rbin_sync: Gray-to-binary decode of rq2, where bit i = XOR of rq2 bits ptrsize..i.
- wfull <= (wgray_next == {~rq2[ptrsize:ptrsize-1], rq2[ptrsize-2:0]}). Full asserts on the same edge that commits the 2**ptrsize-th unread write, so there is zero-cycle latency from the final write.
- wlevel <= (wbin_next - rbin_sync) modulo 2**(ptrsize+1). wlevel = 2**ptrsize exactly when wfull=1.
- walmost_full <= (2**ptrsize - level_next) <= af_margin, where level_next is the same value loaded into wlevel.
- Read-pointer advance latency: a change on rptr_gray is reflected in wfull, wlevel and walmost_full 3 rising edges later (2 for the synchronizer, 1 for the output registers). The flags are pessimistic: they may report full late-cleared but never falsely not-full.
- Simultaneous push and read-pointer advance: both are applied in the same evaluation; level remains consistent.
- Reset mid-operation: all state returns to 0 immediately, regardless of wr_en. The read domain is reset in the same system reset.
- No internal state machine beyond the counter. Flag logic must be glitch-free as seen by consumers, because all flags are registered.

Test Plan:
- ptrsize=3, rptr_gray held 0, reset, then wr_en=1 for 8 cycles -> waddr 0..7; wptr_gray sequence 1,3,2,6,7,5,4,12 (last = bin 8); wfull=1 on the edge of the 8th write; wlevel=8.
- Continue wr_en=1 while full for 3 cycles -> wbin and wptr_gray frozen at bin 8; wr_err=1 for each of those 3 cycles; wfull stays 1.
- From full, drive rptr_gray=1 (bin 1) -> wfull falls and wlevel=7 exactly 3 edges later; next write sets waddr=0 and wptr_gray=13 (bin 9), and wfull=1 again.
- af_margin=2 at depth 8: after 5 writes walmost_full=0; after the 6th write walmost_full=1, wlevel=6; with rptr_gray advanced to bin 2, walmost_full=0 after 3 edges.
- Wrap check: with the reader tracking (rptr_gray = writer's wptr_gray delayed by 4 cycles), 40 continuous writes -> wbin wraps 15 to 0 twice, no wfull, and wptr_gray Hamming distance = 1 on every change.
- Assert rst during continuous writes with wlevel=5 -> all outputs 0 immediately (asynchronous, before the next clk edge); first write after release gives waddr=0 and wptr_gray=1.
